p4_router_dequeue_scheduler: RTL and testbench

P4_ROUTER_DEQUEUE_SCHEDULER -- requirements
Module: p4_router_dequeue_scheduler

---
 rtl/p4_router_dequeue_scheduler.sv | 149 ++++++++++++++
 tb/tb_p4_router_dequeue_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_router_dequeue_scheduler.sv
// Round-robin egress-port / strict-priority queue dequeue scheduler with one outstanding grant.
// Optional per-port grant counters are enabled by defining P4_ROUTER_DEQ_SCHED_STATS_EN.
module p4_router_dequeue_scheduler #(
  parameter int NUM_EGR_PORTS           = 4,
  parameter int NUM_QUEUES_PER_EGR_PORT = 4,
  localparam int NUM_QUEUES             = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT,
  localparam int NUM_QUEUES_LOG         = $clog2(NUM_QUEUES),
  localparam int NUM_EGR_PORTS_LOG      = $clog2(NUM_EGR_PORTS)
) (
  input  logic                         core_clk_ifc,
  input  logic                         core_areset_ifc,
  input  logic [NUM_QUEUES-1:0]        queue_nonempty,
  input  logic [NUM_EGR_PORTS-1:0]     egr_buf_ready,
  input  logic [NUM_EGR_PORTS-1:0]     egr_port_enable,
  input  logic                         sched_en,
  output logic                         grant_valid,
  input  logic                         grant_ready,
  output logic [NUM_QUEUES_LOG-1:0]    grant_queue,
  output logic [NUM_EGR_PORTS_LOG-1:0] grant_port,
  input  logic                         pkt_done,
  output logic                         busy
`ifdef P4_ROUTER_DEQ_SCHED_STATS_EN
  ,
  input  logic                         cnt_clear,
  output logic [NUM_EGR_PORTS*32-1:0]  grant_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StOffer, StXfer} state_e;

  state_e                       state_q, state_d;
  logic [NUM_EGR_PORTS_LOG-1:0] last_port_q, last_port_d;
  logic [NUM_EGR_PORTS_LOG-1:0] grant_port_q, grant_port_d;
  logic [NUM_QUEUES_LOG-1:0]    grant_queue_q, grant_queue_d;
  logic [NUM_EGR_PORTS-1:0]     eligible;
  logic                         pick_found;
  logic [NUM_EGR_PORTS_LOG-1:0] pick_port;
  logic [NUM_QUEUES_LOG-1:0]    pick_queue;

  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_EGR_PORTS; p++) begin
      eligible[p] = egr_port_enable[p] & egr_buf_ready[p] &
                    (|queue_nonempty[p*NUM_QUEUES_PER_EGR_PORT +: NUM_QUEUES_PER_EGR_PORT]);
    end
  end

  // Round-robin search starting just after the last served port.
  always_comb begin
    int target;
    target     = 0;
    pick_found = 1'b0;
    pick_port  = '0;
    for (int off = 1; off <= NUM_EGR_PORTS; off++) begin
      target = int'(last_port_q) + off;
      if (target >= NUM_EGR_PORTS) target = target - NUM_EGR_PORTS;
      for (int p = 0; p < NUM_EGR_PORTS; p++) begin
        if (!pick_found && (p == target) && eligible[p]) begin
          pick_found = 1'b1;
          pick_port  = NUM_EGR_PORTS_LOG'(p);
        end
      end
    end
  end

  // Descending scan so the lowest-numbered (highest priority) queue wins.
  always_comb begin
    pick_queue = '0;
    for (int q = NUM_QUEUES - 1; q >= 0; q--) begin
      if (queue_nonempty[q] && ((q / NUM_QUEUES_PER_EGR_PORT) == int'(pick_port))) begin
        pick_queue = NUM_QUEUES_LOG'(q);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_port_d   = last_port_q;
    grant_port_d  = grant_port_q;
    grant_queue_d = grant_queue_q;
    unique case (state_q)
      StIdle: begin
        if (sched_en && pick_found) begin
          grant_port_d  = pick_port;
          grant_queue_d = pick_queue;
          state_d       = StOffer;
        end
      end
      StOffer: begin
        if (grant_ready) state_d = StXfer;
      end
      StXfer: begin
        if (pkt_done) begin
          last_port_d = grant_port_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge core_clk_ifc or posedge core_areset_ifc) begin
    if (core_areset_ifc) begin
      state_q       <= StIdle;
      last_port_q   <= NUM_EGR_PORTS_LOG'(NUM_EGR_PORTS - 1);
      grant_port_q  <= '0;
      grant_queue_q <= '0;
    end else begin
      state_q       <= state_d;
      last_port_q   <= last_port_d;
      grant_port_q  <= grant_port_d;
      grant_queue_q <= grant_queue_d;
    end
  end

  assign grant_valid = (state_q == StOffer);
  assign busy        = (state_q != StIdle);
  assign grant_port  = grant_port_q;
  assign grant_queue = grant_queue_q;

`ifdef P4_ROUTER_DEQ_SCHED_STATS_EN
  logic        handshake;
  logic [31:0] grant_cnt_q [NUM_EGR_PORTS];

  assign handshake = (state_q == StOffer) & grant_ready;

  // Saturating counters; clear has priority over a same-cycle increment.
  always_ff @(posedge core_clk_ifc or posedge core_areset_ifc) begin
    if (core_areset_ifc) begin
      for (int p = 0; p < NUM_EGR_PORTS; p++) grant_cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_EGR_PORTS; p++) begin
        if (cnt_clear) begin
          grant_cnt_q[p] <= '0;
        end else if (handshake && (grant_port_q == NUM_EGR_PORTS_LOG'(p)) &&
                     (grant_cnt_q[p] != '1)) begin
          grant_cnt_q[p] <= grant_cnt_q[p] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int p = 0; p < NUM_EGR_PORTS; p++) grant_cnt[32*p +: 32] = grant_cnt_q[p];
  end
`endif

endmodule

// File: tb/tb_p4_router_dequeue_scheduler.sv
// Bench for p4_router_dequeue_scheduler: directed table, corner sequences, randomized model check.
// Counter checks are compiled in when P4_ROUTER_DEQ_SCHED_STATS_EN is defined.
module tb_p4_router_dequeue_scheduler;
  localparam int NP = 4;
  localparam int NQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] qne;
  logic [3:0]  brdy, pen;
  logic        sched_en, grant_ready, pkt_done;
  logic        gv, busy;
  logic [3:0]  gq;
  logic [1:0]  gp;
`ifdef P4_ROUTER_DEQ_SCHED_STATS_EN
  logic         cnt_clear;
  logic [127:0] grant_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  p4_router_dequeue_scheduler #(
    .NUM_EGR_PORTS          (NP),
    .NUM_QUEUES_PER_EGR_PORT(NQ)
  ) dut (
    .core_clk_ifc   (clk),
    .core_areset_ifc(rst),
    .queue_nonempty (qne),
    .egr_buf_ready  (brdy),
    .egr_port_enable(pen),
    .sched_en       (sched_en),
    .grant_valid    (gv),
    .grant_ready    (grant_ready),
    .grant_queue    (gq),
    .grant_port     (gp),
    .pkt_done       (pkt_done),
    .busy           (busy)
`ifdef P4_ROUTER_DEQ_SCHED_STATS_EN
    ,
    .cnt_clear      (cnt_clear),
    .grant_cnt      (grant_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    qne         = '0;
    brdy        = '1;
    pen         = '1;
    sched_en    = 1'b0;
    grant_ready = 1'b0;
    pkt_done    = 1'b0;
`ifdef P4_ROUTER_DEQ_SCHED_STATS_EN
    cnt_clear   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gv(input string name, input int budget);
    int n = 0;
    while (gv !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(gv), 32'd1);
  endtask

  // Reference model: idle / offered / transferring phases with a round-robin pointer.
  int m_phase, m_last, m_gp, m_gq;

  function automatic void model_reset();
    m_phase = 0;
    m_last  = NP - 1;
    m_gp    = 0;
    m_gq    = 0;
  endfunction

  function automatic void model_step();
    case (m_phase)
      0: if (sched_en) begin
        for (int k = 1; k <= NP; k++) begin
          int p;
          p = (m_last + k) % NP;
          if (pen[p] && brdy[p] && qne[p*NQ +: NQ] != 0) begin
            for (int pr = NQ - 1; pr >= 0; pr--) if (qne[p*NQ + pr]) m_gq = p * NQ + pr;
            m_gp    = p;
            m_phase = 1;
            break;
          end
        end
      end
      1: if (grant_ready) m_phase = 2;
      default: if (pkt_done) begin
        m_last  = m_gp;
        m_phase = 0;
      end
    endcase
  endfunction

  typedef struct {
    logic [15:0] qne;
    logic [3:0]  brdy;
    logic [3:0]  exp_q;
    logic [1:0]  exp_p;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_seq[5];
    tbl[0] = '{16'h000E, 4'hF, 4'd1,  2'd0};
    tbl[1] = '{16'h0001, 4'hF, 4'd0,  2'd0};
    tbl[2] = '{16'h00F0, 4'hF, 4'd4,  2'd1};
    tbl[3] = '{16'h8000, 4'hF, 4'd15, 2'd3};
    tbl[4] = '{16'h0C00, 4'hF, 4'd10, 2'd2};
    tbl[5] = '{16'h1010, 4'hF, 4'd4,  2'd1};
    tbl[6] = '{16'h0011, 4'hE, 4'd4,  2'd1};
    tbl[7] = '{16'hFFFF, 4'h8, 4'd12, 2'd3};
    tbl[8] = '{16'h2200, 4'hB, 4'd13, 2'd3};

    // Single grant from reset: latency of exactly one cycle, port/queue selection.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      check("rst_gv", 32'(gv), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_gq", 32'(gq), 0);
      check("rst_gp", 32'(gp), 0);
      qne      = tbl[i].qne;
      brdy     = tbl[i].brdy;
      sched_en = 1'b1;
      @(negedge clk);
      check("tbl_gv", 32'(gv), 1);
      check("tbl_gq", 32'(gq), 32'(tbl[i].exp_q));
      check("tbl_gp", 32'(gp), 32'(tbl[i].exp_p));
    end

    // Round robin over 16'h1111 with grant_ready tied high.
    do_reset();
    exp_seq     = '{0, 4, 8, 12, 0};
    qne         = 16'h1111;
    grant_ready = 1'b1;
    sched_en    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_gv("rr_gv_timeout", 10);
      check("rr_gq", 32'(gq), 32'(exp_seq[i]));
      @(negedge clk);
      check("rr_gv_drop", 32'(gv), 0);
      check("rr_busy", 32'(busy), 1);
      @(negedge clk);
      pkt_done = 1'b1;
      @(negedge clk);
      pkt_done = 1'b0;
    end

    // Offer held through backpressure and loss of eligibility.
    do_reset();
    qne      = 16'h0001;
    sched_en = 1'b1;
    @(negedge clk);
    check("hold_gv0", 32'(gv), 1);
    brdy[0]  = 1'b0;
    sched_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_gv", 32'(gv), 1);
      check("hold_gq", 32'(gq), 0);
    end
    grant_ready = 1'b1;
    @(negedge clk);
    check("hold_hs_gv", 32'(gv), 0);
    check("hold_hs_busy", 32'(busy), 1);

    // pkt_done ignored during OFFER, even on the handshake cycle.
    do_reset();
    qne      = 16'h0100;
    sched_en = 1'b1;
    @(negedge clk);
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    check("pd_offer_gv", 32'(gv), 1);
    check("pd_offer_gq", 32'(gq), 8);
    pkt_done    = 1'b1;
    grant_ready = 1'b1;
    @(negedge clk);
    pkt_done    = 1'b0;
    grant_ready = 1'b0;
    check("pd_hs_gv", 32'(gv), 0);
    check("pd_hs_busy", 32'(busy), 1);
    @(negedge clk);
    check("pd_xfer_busy", 32'(busy), 1);
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    check("pd_idle_busy", 32'(busy), 0);
    qne = 16'h1101;
    @(negedge clk);
    check("pd_next_gq", 32'(gq), 12);
    check("pd_next_gp", 32'(gp), 3);

    // Reset mid-XFER clears outputs immediately; later pkt_done is ignored.
    do_reset();
    qne         = 16'h00F0;
    grant_ready = 1'b1;
    sched_en    = 1'b1;
    wait_gv("arst_gv_timeout", 10);
    @(negedge clk);
    check("arst_pre_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_gv", 32'(gv), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_gq", 32'(gq), 0);
    check("arst_gp", 32'(gp), 0);
    grant_ready = 1'b0;
    qne         = 16'h0011;
    @(negedge clk);
    rst      = 1'b0;
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    check("arst_after_gv", 32'(gv), 1);
    check("arst_after_gp", 32'(gp), 0);
    check("arst_after_gq", 32'(gq), 0);

`ifdef P4_ROUTER_DEQ_SCHED_STATS_EN
    // Counter saturation and clear-over-increment.
    do_reset();
    check("cnt_rst", grant_cnt[63:32], 0);
    dut.grant_cnt_q[1] = 32'hFFFF_FFFE;
    qne         = 16'h00F0;
    grant_ready = 1'b1;
    sched_en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_gv("cnt_gv_timeout", 10);
      @(negedge clk);
      check("cnt_sat", grant_cnt[63:32], 32'hFFFF_FFFF);
      check("cnt_p0", grant_cnt[31:0], 0);
      @(negedge clk);
      pkt_done = 1'b1;
      @(negedge clk);
      pkt_done = 1'b0;
    end
    wait_gv("cnt_clr_timeout", 10);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    check("cnt_clr", grant_cnt[63:32], 0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check("rnd_gv", 32'(gv), 32'(m_phase == 1));
      check("rnd_busy", 32'(busy), 32'(m_phase != 0));
      check("rnd_gq", 32'(gq), 32'(m_gq));
      check("rnd_gp", 32'(gp), 32'(m_gp));
      qne         = 16'($urandom) & 16'($urandom);
      brdy        = 4'($urandom) | 4'($urandom);
      pen         = 4'($urandom) | 4'($urandom);
      sched_en    = ($urandom_range(0, 7) != 0);
      grant_ready = 1'($urandom_range(0, 1));
      pkt_done    = ($urandom_range(0, 3) == 0);
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
